// File: rtl/audio_pkg.sv
// audio_pkg: shared sample type, scheduler states and core channel ids
package audio_pkg;
  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef enum logic [2:0] {IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, DONE} sched_state_t;
  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;
endpackage

// File: rtl/core_resp_timer.sv
// core_resp_timer: loadable down-counter bounding the wait for a core response
module core_resp_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  // reload on request handshake, count down while waiting, park at zero
  always_comb cnt_d = load_i ? W'(TIMEOUT_CYCLES - 1) : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
  assign tc_o = cnt_q == '0;
endmodule

// File: rtl/stereo_filter_scheduler.sv
// stereo_filter_scheduler: time-shares one mono filter core between left and right samples
module stereo_filter_scheduler
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = SAMPLE_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int OVR_CNT_WIDTH  = 8
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     enable_in,
  input  logic [SAMPLE_WIDTH-1:0]  sample_left_in,
  input  logic [SAMPLE_WIDTH-1:0]  sample_right_in,
  input  logic                     sample_valid_in,
  output logic                     core_req_valid_out,
  input  logic                     core_req_ready_in,
  output logic [SAMPLE_WIDTH-1:0]  core_req_data_out,
  output logic                     core_req_chan_out,
  input  logic                     core_resp_valid_in,
  input  logic [SAMPLE_WIDTH-1:0]  core_resp_data_in,
  output logic [SAMPLE_WIDTH-1:0]  left_sample_out,
  output logic [SAMPLE_WIDTH-1:0]  right_sample_out,
  output logic                     new_sample_out,
  output logic                     busy_out,
  output logic                     timeout_out,
  output logic [OVR_CNT_WIDTH-1:0] overrun_count_out
);
  sched_state_t state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] left_q, right_q, left_out_q, right_out_q;
  logic [OVR_CNT_WIDTH-1:0] ovr_q;
  logic new_q, timeout_q, hs, in_wait, tc, resp, expire, accept, bypass;

  assign accept  = sample_valid_in && state_q == IDLE;
  assign bypass  = accept && !enable_in;
  assign hs      = core_req_valid_out && core_req_ready_in;
  assign in_wait = state_q == WAIT_L || state_q == WAIT_R;
  assign resp    = in_wait && core_resp_valid_in;
  assign expire  = in_wait && tc && !core_resp_valid_in;

  core_resp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i (clock_in),
    .rst_i (reset_in),
    .load_i(hs),
    .en_i  (in_wait),
    .tc_o  (tc)
  );

  // next-state: each REQ waits for ready, each WAIT ends on response or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (sample_valid_in && enable_in) ? REQ_L : IDLE;
      REQ_L:   state_d = hs ? WAIT_L : REQ_L;
      WAIT_L:  state_d = (resp || expire) ? REQ_R : WAIT_L;
      REQ_R:   state_d = hs ? WAIT_R : REQ_R;
      WAIT_R:  state_d = (resp || expire) ? DONE : WAIT_R;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock_in) state_q <= reset_in ? IDLE : state_d;

  // sample latches double as result holders; a timeout leaves the raw sample in place
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      left_q      <= '0;
      right_q     <= '0;
      left_out_q  <= '0;
      right_out_q <= '0;
      new_q       <= 1'b0;
      timeout_q   <= 1'b0;
      ovr_q       <= '0;
    end else begin
      if (accept && enable_in) begin
        left_q  <= sample_left_in;
        right_q <= sample_right_in;
      end
      if (resp && state_q == WAIT_L) left_q <= core_resp_data_in;
      if (resp && state_q == WAIT_R) right_q <= core_resp_data_in;
      if (bypass || state_q == DONE) begin
        left_out_q  <= bypass ? sample_left_in : left_q;
        right_out_q <= bypass ? sample_right_in : right_q;
      end
      new_q     <= bypass || state_q == DONE;
      timeout_q <= timeout_q || expire;
      if (sample_valid_in && state_q != IDLE && ovr_q != '1) ovr_q <= ovr_q + 1'b1;
    end
  end

  assign core_req_valid_out = state_q == REQ_L || state_q == REQ_R;
  assign core_req_chan_out  = state_q == REQ_R ? CHAN_RIGHT : CHAN_LEFT;
  assign core_req_data_out  = core_req_chan_out == CHAN_RIGHT ? right_q : left_q;
  assign left_sample_out    = left_out_q;
  assign right_sample_out   = right_out_q;
  assign new_sample_out     = new_q;
  assign busy_out           = state_q != IDLE;
  assign timeout_out        = timeout_q;
  assign overrun_count_out  = ovr_q;
endmodule

// File: tb/tb_stereo_filter_scheduler.sv
// tb_stereo_filter_scheduler: directed scenarios against a simple behavioural filter core
module tb_stereo_filter_scheduler;
  import audio_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_in = 1'b1, enable_in = 1'b0, sample_valid_in = 1'b0, core_req_ready_in = 1'b0;
  logic [15:0] sample_left_in = '0, sample_right_in = '0;
  logic core_resp_valid_in = 1'b0;
  logic [15:0] core_resp_data_in = '0;
  logic core_req_valid_out, core_req_chan_out, new_sample_out, busy_out, timeout_out;
  logic [15:0] core_req_data_out, left_sample_out, right_sample_out;
  logic [7:0] overrun_count_out;

  int vecs = 0, errs = 0;
  int core_mode = 0;
  logic drop_right = 1'b0, pend = 1'b0, inj_v = 1'b0;
  sample_t pend_d = '0;
  logic [15:0] inj_d = '0;

  stereo_filter_scheduler dut (
    .clock_in(clk), .reset_in(reset_in), .enable_in(enable_in),
    .sample_left_in(sample_left_in), .sample_right_in(sample_right_in), .sample_valid_in(sample_valid_in),
    .core_req_valid_out(core_req_valid_out), .core_req_ready_in(core_req_ready_in),
    .core_req_data_out(core_req_data_out), .core_req_chan_out(core_req_chan_out),
    .core_resp_valid_in(core_resp_valid_in), .core_resp_data_in(core_resp_data_in),
    .left_sample_out(left_sample_out), .right_sample_out(right_sample_out),
    .new_sample_out(new_sample_out), .busy_out(busy_out), .timeout_out(timeout_out),
    .overrun_count_out(overrun_count_out)
  );

  // core model: mode 1 negates, mode 2 doubles, mode 0 silent; answers the cycle after a handshake
  always @(negedge clk) begin
    #1;
    core_resp_valid_in = pend | inj_v;
    core_resp_data_in  = pend ? pend_d : inj_d;
    pend   = core_req_valid_out && core_req_ready_in && core_mode != 0 && !(drop_right && core_req_chan_out);
    pend_d = (core_mode == 1) ? -sample_t'(core_req_data_out) : sample_t'(core_req_data_out) <<< 1;
  end

  task automatic pulse(input logic [15:0] l, input logic [15:0] r);
    sample_left_in = l;
    sample_right_in = r;
    sample_valid_in = 1'b1;
    @(negedge clk);
    sample_valid_in = 1'b0;
  endtask

  task automatic test_reset;
    reset_in = 1'b1;
    repeat (2) @(negedge clk);
    reset_in = 1'b0;
    if ({core_req_valid_out, core_req_chan_out, core_req_data_out} !== 18'd0) begin errs++; $display("FAIL rst_req: got %h expected 0", {core_req_valid_out, core_req_chan_out, core_req_data_out}); end vecs++;
    if ({left_sample_out, right_sample_out, new_sample_out, busy_out, timeout_out, overrun_count_out} !== 43'd0) begin errs++; $display("FAIL rst_out: got %h expected 0", {left_sample_out, right_sample_out, new_sample_out, busy_out, timeout_out, overrun_count_out}); end vecs++;
    @(negedge clk);
    if ({busy_out, new_sample_out, core_req_valid_out} !== 3'd0) begin errs++; $display("FAIL rst_idle: got %b expected 000", {busy_out, new_sample_out, core_req_valid_out}); end vecs++;
  endtask

  task automatic test_bypass;
    enable_in = 1'b0; core_mode = 1; core_req_ready_in = 1'b1;
    pulse(16'h1234, 16'hFEDC);
    if ({new_sample_out, left_sample_out, right_sample_out, busy_out, core_req_valid_out} !== {1'b1, 16'h1234, 16'hFEDC, 2'b00}) begin errs++; $display("FAIL byp_out: got %h expected %h", {new_sample_out, left_sample_out, right_sample_out, busy_out, core_req_valid_out}, {1'b1, 16'h1234, 16'hFEDC, 2'b00}); end vecs++;
    @(negedge clk);
    if ({new_sample_out, left_sample_out, right_sample_out, core_req_valid_out} !== {1'b0, 16'h1234, 16'hFEDC, 1'b0}) begin errs++; $display("FAIL byp_hold: got %h expected %h", {new_sample_out, left_sample_out, right_sample_out, core_req_valid_out}, {1'b0, 16'h1234, 16'hFEDC, 1'b0}); end vecs++;
  endtask

  task automatic test_nominal;
    enable_in = 1'b1; core_mode = 1; drop_right = 1'b0; core_req_ready_in = 1'b1;
    pulse(16'h0064, 16'hFF38);
    if ({core_req_valid_out, core_req_chan_out, core_req_data_out} !== {2'b10, 16'h0064}) begin errs++; $display("FAIL nom_req_l: got %h expected %h", {core_req_valid_out, core_req_chan_out, core_req_data_out}, {2'b10, 16'h0064}); end vecs++;
    @(negedge clk);
    if ({core_req_valid_out, busy_out} !== 2'b01) begin errs++; $display("FAIL nom_wait_l: got %b expected 01", {core_req_valid_out, busy_out}); end vecs++;
    @(negedge clk);
    if ({core_req_valid_out, core_req_chan_out, core_req_data_out} !== {2'b11, 16'hFF38}) begin errs++; $display("FAIL nom_req_r: got %h expected %h", {core_req_valid_out, core_req_chan_out, core_req_data_out}, {2'b11, 16'hFF38}); end vecs++;
    @(negedge clk);
    if ({core_req_valid_out, busy_out, new_sample_out} !== 3'b010) begin errs++; $display("FAIL nom_wait_r: got %b expected 010", {core_req_valid_out, busy_out, new_sample_out}); end vecs++;
    @(negedge clk);
    if ({new_sample_out, busy_out} !== 2'b01) begin errs++; $display("FAIL nom_done: got %b expected 01", {new_sample_out, busy_out}); end vecs++;
    sample_left_in = 16'h0055; sample_right_in = 16'h0066; sample_valid_in = 1'b1;
    @(negedge clk);
    sample_valid_in = 1'b0;
    if ({new_sample_out, left_sample_out, right_sample_out, busy_out, overrun_count_out} !== {1'b1, 16'hFF9C, 16'h00C8, 1'b0, 8'd1}) begin errs++; $display("FAIL nom_out: got %h expected %h", {new_sample_out, left_sample_out, right_sample_out, busy_out, overrun_count_out}, {1'b1, 16'hFF9C, 16'h00C8, 1'b0, 8'd1}); end vecs++;
    @(negedge clk);
    if ({new_sample_out, busy_out, left_sample_out, right_sample_out} !== {2'b00, 16'hFF9C, 16'h00C8}) begin errs++; $display("FAIL nom_hold: got %h expected %h", {new_sample_out, busy_out, left_sample_out, right_sample_out}, {2'b00, 16'hFF9C, 16'h00C8}); end vecs++;
  endtask

  task automatic test_backpressure;
    int n;
    enable_in = 1'b1; core_mode = 1; core_req_ready_in = 1'b0;
    pulse(16'h012C, 16'hFFF9);
    for (int i = 0; i < 50; i++) begin
      if ({core_req_valid_out, core_req_chan_out, core_req_data_out, timeout_out} !== {2'b10, 16'h012C, 1'b0}) begin errs++; $display("FAIL bp_stable cycle %0d: got %h expected %h", i, {core_req_valid_out, core_req_chan_out, core_req_data_out, timeout_out}, {2'b10, 16'h012C, 1'b0}); end vecs++;
      @(negedge clk);
    end
    core_req_ready_in = 1'b1;
    n = 0;
    while (!new_sample_out && n < 20) begin @(negedge clk); n++; end
    if ({new_sample_out, left_sample_out, right_sample_out, timeout_out} !== {1'b1, 16'hFED4, 16'h0007, 1'b0}) begin errs++; $display("FAIL bp_out: got %h expected %h", {new_sample_out, left_sample_out, right_sample_out, timeout_out}, {1'b1, 16'hFED4, 16'h0007, 1'b0}); end vecs++;
    @(negedge clk);
  endtask

  task automatic test_overrun;
    int n;
    enable_in = 1'b1; core_mode = 1; core_req_ready_in = 1'b1;
    pulse(16'h000B, 16'h0016);
    repeat (2) @(negedge clk);
    pulse(16'h0AAA, 16'h0BBB);
    if (overrun_count_out !== 8'd2) begin errs++; $display("FAIL ovr_one: got %0d expected 2", overrun_count_out); end vecs++;
    n = 0;
    while (!new_sample_out && n < 20) begin @(negedge clk); n++; end
    if ({new_sample_out, left_sample_out, right_sample_out} !== {1'b1, 16'hFFF5, 16'hFFEA}) begin errs++; $display("FAIL ovr_first_pair: got %h expected %h", {new_sample_out, left_sample_out, right_sample_out}, {1'b1, 16'hFFF5, 16'hFFEA}); end vecs++;
    @(negedge clk);
    core_req_ready_in = 1'b0;
    pulse(16'h0003, 16'h0004);
    sample_left_in = 16'hDEAD; sample_right_in = 16'hBEEF; sample_valid_in = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 252 && overrun_count_out !== 8'd254) begin errs++; $display("FAIL ovr_254: got %0d expected 254", overrun_count_out); end
      if (i == 253 && overrun_count_out !== 8'd255) begin errs++; $display("FAIL ovr_255: got %0d expected 255", overrun_count_out); end
    end
    vecs += 2;
    sample_valid_in = 1'b0;
    if (overrun_count_out !== 8'hFF) begin errs++; $display("FAIL ovr_sat: got %0d expected 255", overrun_count_out); end vecs++;
    core_req_ready_in = 1'b1;
    n = 0;
    while (!new_sample_out && n < 20) begin @(negedge clk); n++; end
    if ({new_sample_out, left_sample_out, right_sample_out, overrun_count_out} !== {1'b1, 16'hFFFD, 16'hFFFC, 8'hFF}) begin errs++; $display("FAIL ovr_held_pair: got %h expected %h", {new_sample_out, left_sample_out, right_sample_out, overrun_count_out}, {1'b1, 16'hFFFD, 16'hFFFC, 8'hFF}); end vecs++;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    enable_in = 1'b1; core_mode = 2; drop_right = 1'b1; core_req_ready_in = 1'b1;
    pulse(16'h0005, 16'h0007);
    repeat (1026) @(negedge clk);
    if ({busy_out, timeout_out, core_req_valid_out} !== 3'b100) begin errs++; $display("FAIL to_last_wait: got %b expected 100", {busy_out, timeout_out, core_req_valid_out}); end vecs++;
    @(negedge clk);
    if ({timeout_out, new_sample_out, busy_out} !== 3'b101) begin errs++; $display("FAIL to_flag: got %b expected 101", {timeout_out, new_sample_out, busy_out}); end vecs++;
    @(negedge clk);
    if ({new_sample_out, left_sample_out, right_sample_out, timeout_out, busy_out} !== {1'b1, 16'h000A, 16'h0007, 2'b10}) begin errs++; $display("FAIL to_out: got %h expected %h", {new_sample_out, left_sample_out, right_sample_out, timeout_out, busy_out}, {1'b1, 16'h000A, 16'h0007, 2'b10}); end vecs++;
    inj_d = 16'h7777; inj_v = 1'b1;
    @(negedge clk);
    inj_v = 1'b0;
    @(negedge clk);
    if ({new_sample_out, left_sample_out, right_sample_out, busy_out, timeout_out} !== {1'b0, 16'h000A, 16'h0007, 2'b01}) begin errs++; $display("FAIL to_late_resp: got %h expected %h", {new_sample_out, left_sample_out, right_sample_out, busy_out, timeout_out}, {1'b0, 16'h000A, 16'h0007, 2'b01}); end vecs++;
    drop_right = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    enable_in = 1'b1; core_mode = 0; core_req_ready_in = 1'b1;
    pulse(16'h0009, 16'h0009);
    @(negedge clk);
    if ({busy_out, core_req_valid_out} !== 2'b10) begin errs++; $display("FAIL rw_in_wait: got %b expected 10", {busy_out, core_req_valid_out}); end vecs++;
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    if ({left_sample_out, right_sample_out, new_sample_out, busy_out, timeout_out, overrun_count_out, core_req_valid_out} !== 44'd0) begin errs++; $display("FAIL rw_cleared: got %h expected 0", {left_sample_out, right_sample_out, new_sample_out, busy_out, timeout_out, overrun_count_out, core_req_valid_out}); end vecs++;
    inj_d = 16'h1111; inj_v = 1'b1;
    @(negedge clk);
    inj_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if ({new_sample_out, busy_out, left_sample_out, right_sample_out, core_req_valid_out} !== 35'd0) begin errs++; $display("FAIL rw_ignore %0d: got %h expected 0", i, {new_sample_out, busy_out, left_sample_out, right_sample_out, core_req_valid_out}); end vecs++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_bypass;
    test_nominal;
    test_backpressure;
    test_overrun;
    test_timeout;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
